// File: rtl/paddle_ctrl_multi.sv
// paddle_ctrl_multi: NCH independent paddle position controllers.
// Each raw button bit goes through a 2-flop synchronizer and a debouncer. A shared
// free-running tick paces saturating position updates in [0, MAX_POS-PADDLE_H].
// Optional acceleration is compiled in when PADDLE_CTRL_ACCEL_EN is defined;
// without it every move is a single pixel.

module paddle_ctrl_multi #(
    parameter int unsigned NCH        = 2,
    parameter int unsigned COORD_W    = 9,
    parameter int unsigned MAX_POS    = 480,
    parameter int unsigned PADDLE_H   = 64,
    parameter int unsigned INIT_POS   = 208,
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned HOLD_TICKS = 8,
    parameter int unsigned FAST_STEP  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NCH-1:0]         pushup,
    input  logic [NCH-1:0]         pushdown,
    output logic [NCH*COORD_W-1:0] coord,
    output logic [NCH-1:0]         at_top,
    output logic [NCH-1:0]         at_bottom
);

    localparam int unsigned LIM      = MAX_POS - PADDLE_H;
    localparam int unsigned NB       = 2 * NCH;
    localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam int unsigned TICK_MAX = TICK_DIV - 1;
    localparam int unsigned DEB_MAX  = DEB_CYCLES - 1;

    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_MAX[TICK_W-1:0];
    localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_MAX[DEB_W-1:0];
    localparam logic [COORD_W-1:0] LIM_C     = LIM[COORD_W-1:0];
    localparam logic [COORD_W-1:0] INIT_C    = INIT_POS[COORD_W-1:0];
    localparam logic [COORD_W:0]   LIM_X     = LIM[COORD_W:0];
    localparam logic [COORD_W:0]   ONE_X     = {{COORD_W{1'b0}}, 1'b1};

`ifdef PADDLE_CTRL_ACCEL_EN
    localparam int unsigned        HOLD_W    = $clog2(HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_TICKS[HOLD_W-1:0];
    localparam logic [COORD_W:0]   FAST_X    = FAST_STEP[COORD_W:0];
`endif

    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick;

    // Buttons packed as {down, up}: bit i is up of channel i, bit NCH+i is down.
    logic [NB-1:0]    btn_raw;
    logic [NB-1:0]    sync1_q;
    logic [NB-1:0]    sync2_q;
    logic [NB-1:0]    deb_q;
    logic [DEB_W-1:0] deb_cnt_q [NB];

    assign btn_raw = {pushdown, pushup};
    assign tick    = (tick_cnt_q == TICK_LAST);

    // Shared movement tick counter; runs regardless of enable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
        end
    end

    // Two-flop synchronizer for every raw button bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level after DEB_CYCLES consecutive samples that differ
    // from the current output; any sample equal to the output restarts the count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (!reset) begin
                deb_cnt_q[i] <= '0;
                deb_q[i]     <= 1'b0;
            end else if (sync2_q[i] == deb_q[i]) begin
                deb_cnt_q[i] <= '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                deb_cnt_q[i] <= '0;
                deb_q[i]     <= sync2_q[i];
            end else begin
                deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [COORD_W-1:0] pos_q;
        logic [COORD_W-1:0] pos_d;
        logic [COORD_W:0]   step;
        logic [COORD_W:0]   sum_up;
        logic               mv_up;
        logic               mv_dn;

        assign mv_up  = deb_q[g] & ~deb_q[NCH+g];
        assign mv_dn  = deb_q[NCH+g] & ~deb_q[g];
        assign sum_up = {1'b0, pos_q} + step;

`ifdef PADDLE_CTRL_ACCEL_EN
        logic [HOLD_W-1:0] hold_q;
        logic [HOLD_W-1:0] hold_d;
        logic              dir_q;
        logic              dir_d;
        logic              same_dir;

        // dir_q is only meaningful while a run is in progress (hold_q != 0).
        assign same_dir = (hold_q != '0) && (dir_q == mv_up);
        assign step     = (same_dir && (hold_q == HOLD_LAST)) ? FAST_X : ONE_X;

        // Hold-run bookkeeping; a reversal starts a fresh run counting this tick.
        always_comb begin
            hold_d = hold_q;
            dir_d  = dir_q;
            if (!enable) begin
                hold_d = '0;
            end else if (tick) begin
                if (mv_up || mv_dn) begin
                    if (!same_dir) begin
                        hold_d = HOLD_W'(1);
                    end else if (hold_q != HOLD_LAST) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                    dir_d = mv_up;
                end else begin
                    hold_d = '0;
                end
            end
        end

        // Hold counter and last-direction registers.
        always_ff @(posedge clk) begin
            if (!reset) begin
                hold_q <= '0;
                dir_q  <= 1'b0;
            end else begin
                hold_q <= hold_d;
                dir_q  <= dir_d;
            end
        end
`else
        assign step = ONE_X;
`endif

        // Saturating position update, one step per enabled tick.
        always_comb begin
            pos_d = pos_q;
            if (enable && tick) begin
                if (mv_up) begin
                    pos_d = (sum_up > LIM_X) ? LIM_C : sum_up[COORD_W-1:0];
                end else if (mv_dn) begin
                    pos_d = ({1'b0, pos_q} < step) ? '0 : pos_q - step[COORD_W-1:0];
                end
            end
        end

        // Position register.
        always_ff @(posedge clk) begin
            if (!reset) begin
                pos_q <= INIT_C;
            end else begin
                pos_q <= pos_d;
            end
        end

        assign coord[g*COORD_W +: COORD_W] = pos_q;
        assign at_top[g]                   = (pos_q == LIM_C);
        assign at_bottom[g]                = (pos_q == '0);
    end

endmodule

// File: tb/tb_paddle_ctrl_multi.sv
// Self-checking bench for paddle_ctrl_multi (NCH=2, TICK_DIV=4, DEB_CYCLES=3,
// HOLD_TICKS=4, FAST_STEP=4). Expected positions are queued when stimulus is applied
// and popped after each movement tick. Expectations follow PADDLE_CTRL_ACCEL_EN.

module tb_paddle_ctrl_multi;

    localparam int unsigned NCH      = 2;
    localparam int unsigned CW       = 9;
    localparam int unsigned TICK_DIV = 4;
    localparam int          HOLD     = 4;
    localparam int          FAST     = 4;
    localparam int          LIM      = 416;
`ifdef PADDLE_CTRL_ACCEL_EN
    localparam bit ACCEL = 1'b1;
`else
    localparam bit ACCEL = 1'b0;
`endif

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              enable   = 1'b0;
    logic [NCH-1:0]    pushup   = '0;
    logic [NCH-1:0]    pushdown = '0;
    logic [NCH*CW-1:0] coord;
    logic [NCH-1:0]    at_top;
    logic [NCH-1:0]    at_bottom;
    logic [CW-1:0]     pos0;
    logic [CW-1:0]     pos1;

    int              n_checks = 0;
    int              n_pass   = 0;
    logic [2*CW-1:0] exp_q [$];
    int unsigned     ph       = 0;

    assign pos0 = coord[CW-1:0];
    assign pos1 = coord[2*CW-1:CW];

    paddle_ctrl_multi #(
        .NCH        (2),
        .COORD_W    (9),
        .MAX_POS    (480),
        .PADDLE_H   (64),
        .INIT_POS   (208),
        .TICK_DIV   (4),
        .DEB_CYCLES (3),
        .HOLD_TICKS (4),
        .FAST_STEP  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .pushup    (pushup),
        .pushdown  (pushdown),
        .coord     (coord),
        .at_top    (at_top),
        .at_bottom (at_bottom)
    );

    always #5 clk = ~clk;

    // Independent tick phase tracker: ph == TICK_DIV-1 means the next edge is a tick.
    always @(posedge clk) begin
        if (!reset) ph <= 0;
        else if (ph == TICK_DIV - 1) ph <= 0;
        else ph <= ph + 1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns #1 after the next tick edge.
    task automatic wait_tick();
        int guard = 0;
        while (ph != TICK_DIV - 1 && guard < 2 * TICK_DIV) begin
            @(posedge clk);
            #1;
            guard++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic void push_exp(input int p0, input int p1);
        exp_q.push_back({p1[CW-1:0], p0[CW-1:0]});
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        enable = 1'b0;
        pushup = '0;
        pushdown = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        n_checks++;
        if (pos0 !== 9'd208) $display("FAIL reset_coord0: got %0d, required 208", pos0);
        else n_pass++;
        n_checks++;
        if (pos1 !== 9'd208) $display("FAIL reset_coord1: got %0d, required 208", pos1);
        else n_pass++;
        n_checks++;
        if (at_top !== 2'b00) $display("FAIL reset_at_top: got %b, required 00", at_top);
        else n_pass++;
        n_checks++;
        if (at_bottom !== 2'b00) $display("FAIL reset_at_bottom: got %b, required 00", at_bottom);
        else n_pass++;
    endtask

    task automatic test_accel_up();
        int seq [6];
        logic [2*CW-1:0] got;
`ifdef PADDLE_CTRL_ACCEL_EN
        seq = '{209, 210, 211, 212, 216, 220};
`else
        seq = '{209, 210, 211, 212, 213, 214};
`endif
        pushup[0] = 1'b1;
        wait_cycles(8);
        wait_tick();
        enable = 1'b1;
        for (int k = 0; k < 6; k++) push_exp(seq[k], 208);
        for (int k = 0; k < 6; k++) begin
            wait_tick();
            got = exp_q.pop_front();
            n_checks++;
            if (coord !== got)
                $display("FAIL accel_up tick %0d: ch1/ch0 = %0d/%0d, required %0d/%0d",
                         k + 1, pos1, pos0, got[2*CW-1:CW], got[CW-1:0]);
            else n_pass++;
        end
        enable = 1'b0;
        pushup[0] = 1'b0;
    endtask

    task automatic test_down_sat();
        int seq [8];
        int c0 = ACCEL ? 220 : 214;
        logic [2*CW-1:0] got;
`ifdef PADDLE_CTRL_ACCEL_EN
        seq = '{5, 4, 3, 2, 0, 0, 0, 0};
`else
        seq = '{5, 4, 3, 2, 1, 0, 0, 0};
`endif
        pushdown[1] = 1'b1;
        wait_cycles(8);
        // Four-tick bursts never reach the fast step; walk ch1 down to 6.
        for (int b = 0; b < 51; b++) begin
            int n = (b < 50) ? 4 : 2;
            push_exp(c0, (b < 50) ? 208 - 4 * (b + 1) : 6);
            wait_tick();
            enable = 1'b1;
            repeat (n) wait_tick();
            enable = 1'b0;
            got = exp_q.pop_front();
            n_checks++;
            if (coord !== got)
                $display("FAIL down_burst %0d: ch1/ch0 = %0d/%0d, required %0d/%0d",
                         b, pos1, pos0, got[2*CW-1:CW], got[CW-1:0]);
            else n_pass++;
        end
        wait_tick();
        enable = 1'b1;
        for (int k = 0; k < 8; k++) push_exp(c0, seq[k]);
        for (int k = 0; k < 8; k++) begin
            wait_tick();
            got = exp_q.pop_front();
            n_checks++;
            if (coord !== got)
                $display("FAIL down_sat tick %0d: ch1/ch0 = %0d/%0d, required %0d/%0d",
                         k + 1, pos1, pos0, got[2*CW-1:CW], got[CW-1:0]);
            else n_pass++;
        end
        n_checks++;
        if (at_bottom !== 2'b10) $display("FAIL down_at_bottom: got %b, required 10", at_bottom);
        else n_pass++;
        n_checks++;
        if (at_top !== 2'b00) $display("FAIL down_at_top: got %b, required 00", at_top);
        else n_pass++;
        enable = 1'b0;
    endtask

    task automatic test_no_move();
        int seq [22];
        int c0;
        logic [2*CW-1:0] got;
`ifdef PADDLE_CTRL_ACCEL_EN
        seq = '{221, 222, 223, 224, 228, 232, 232, 232, 232, 232, 232,
                232, 232, 232, 232, 232, 232, 233, 234, 235, 236, 240};
`else
        seq = '{215, 216, 217, 218, 219, 220, 220, 220, 220, 220, 220,
                220, 220, 220, 220, 220, 220, 221, 222, 223, 224, 225};
`endif
        c0 = seq[21];
        pushup[0] = 1'b1;
        wait_cycles(8);
        wait_tick();
        enable = 1'b1;
        for (int k = 0; k < 22; k++) push_exp(seq[k], 0);
        for (int k = 1; k <= 22; k++) begin
            wait_tick();
            got = exp_q.pop_front();
            n_checks++;
            if (coord !== got)
                $display("FAIL both_held tick %0d: ch1/ch0 = %0d/%0d, required %0d/%0d",
                         k, pos1, pos0, got[2*CW-1:CW], got[CW-1:0]);
            else n_pass++;
            if (k == 5) pushdown[0] = 1'b1;
            if (k == 16) pushdown[0] = 1'b0;
        end
        enable = 1'b0;
        for (int k = 0; k < 10; k++) push_exp(c0, 0);
        push_exp(c0 + 1, 0);
        for (int k = 0; k < 11; k++) begin
            wait_tick();
            got = exp_q.pop_front();
            n_checks++;
            if (coord !== got)
                $display("FAIL enable_low tick %0d: ch1/ch0 = %0d/%0d, required %0d/%0d",
                         k + 1, pos1, pos0, got[2*CW-1:CW], got[CW-1:0]);
            else n_pass++;
            if (k == 9) enable = 1'b1;
        end
        enable = 1'b0;
        pushup[0] = 1'b0;
    endtask

    task automatic test_glitch();
        int g0 = ACCEL ? 241 : 226;
        logic [2*CW-1:0] got;
        wait_cycles(8);
        wait_tick();
        enable = 1'b1;
        pushup[0] = 1'b1;
        for (int k = 0; k < 3; k++) push_exp(g0, 0);
        wait_cycles(2);
        pushup[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_tick();
            got = exp_q.pop_front();
            n_checks++;
            if (coord !== got)
                $display("FAIL glitch tick %0d: ch1/ch0 = %0d/%0d, required %0d/%0d",
                         k + 1, pos1, pos0, got[2*CW-1:CW], got[CW-1:0]);
            else n_pass++;
        end
        pushup[0] = 1'b1;
        for (int k = 0; k < 3; k++) push_exp(g0 + 1, 0);
        wait_cycles(6);
        pushup[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_tick();
            got = exp_q.pop_front();
            n_checks++;
            if (coord !== got)
                $display("FAIL pulse tick %0d: ch1/ch0 = %0d/%0d, required %0d/%0d",
                         k + 1, pos1, pos0, got[2*CW-1:CW], got[CW-1:0]);
            else n_pass++;
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_fast();
        int p = ACCEL ? 242 : 227;
        int h = 0;
        int step;
        int guard = 0;
        logic [2*CW-1:0] got;
        pushup[0] = 1'b1;
        wait_cycles(8);
        // Two slow ticks put ch0 on a grid where the fast run lands on 300.
        wait_tick();
        enable = 1'b1;
        repeat (2) wait_tick();
        enable = 1'b0;
        p = p + 2;
        wait_tick();
        enable = 1'b1;
        while (p < 300 && guard < 200) begin
            step = (ACCEL && h == HOLD) ? FAST : 1;
            p = (p + step > LIM) ? LIM : p + step;
            h = (h == HOLD) ? h : h + 1;
            push_exp(p, 0);
            wait_tick();
            got = exp_q.pop_front();
            n_checks++;
            if (coord !== got)
                $display("FAIL climb tick %0d: ch1/ch0 = %0d/%0d, required %0d/%0d",
                         guard + 1, pos1, pos0, got[2*CW-1:CW], got[CW-1:0]);
            else n_pass++;
            guard++;
        end
        // Reset lands on what would have been a tick edge.
        wait_cycles(3);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        n_checks++;
        if (coord !== {9'd208, 9'd208})
            $display("FAIL reset_mid_move: ch1/ch0 = %0d/%0d, required 208/208", pos1, pos0);
        else n_pass++;
        push_exp(208, 208);
        push_exp(209, 207);
        for (int k = 0; k < 2; k++) begin
            wait_tick();
            got = exp_q.pop_front();
            n_checks++;
            if (coord !== got)
                $display("FAIL post_reset tick %0d: ch1/ch0 = %0d/%0d, required %0d/%0d",
                         k + 1, pos1, pos0, got[2*CW-1:CW], got[CW-1:0]);
            else n_pass++;
        end
    endtask

    task automatic test_limits();
        int p0 = 209;
        int h0 = 1;
        int p1 = 207;
        int h1 = 1;
        int step;
        int extra = 0;
        logic [2*CW-1:0] got;
        for (int k = 0; k < 300 && extra < 4; k++) begin
            step = (ACCEL && h0 == HOLD) ? FAST : 1;
            p0 = (p0 + step > LIM) ? LIM : p0 + step;
            h0 = (h0 == HOLD) ? h0 : h0 + 1;
            step = (ACCEL && h1 == HOLD) ? FAST : 1;
            p1 = (p1 < step) ? 0 : p1 - step;
            h1 = (h1 == HOLD) ? h1 : h1 + 1;
            push_exp(p0, p1);
            wait_tick();
            got = exp_q.pop_front();
            n_checks++;
            if (coord !== got)
                $display("FAIL limits tick %0d: ch1/ch0 = %0d/%0d, required %0d/%0d",
                         k + 1, pos1, pos0, got[2*CW-1:CW], got[CW-1:0]);
            else n_pass++;
            if (p0 == LIM && p1 == 0) extra++;
        end
        n_checks++;
        if (at_top !== 2'b01) $display("FAIL limit_at_top: got %b, required 01", at_top);
        else n_pass++;
        n_checks++;
        if (at_bottom !== 2'b10) $display("FAIL limit_at_bottom: got %b, required 10", at_bottom);
        else n_pass++;
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_accel_up();
        test_down_sat();
        test_no_move();
        test_glitch();
        test_reset_fast();
        test_limits();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: run did not complete, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
